// File: rtl/scanner_serial_tx_pkg.sv
// Shared definitions for the scanner-to-transfer-center serial link.
package scanner_serial_tx_pkg;

  // Bits per serial word on the link.
  localparam int BYTE_W = 8;

  // Bit order on the wire; the receiver assembles bytes with the same order.
  localparam bit MSB_FIRST = 1'b1;

  // Transmitter states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SHIFT   = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/scanner_serial_tx_byte_fifo.sv
// Show-ahead circular byte queue feeding the serial shifter.
// A push into a full queue is dropped and flagged unless a pop frees a slot the same cycle.
module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic          w_do_pop;
  logic          w_do_push;

  // A pop in the same cycle frees the slot a push into a full queue needs.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  assign rdata    = r_mem[r_rd_ptr];
  assign count    = r_count;
  assign full     = (r_count == FULL_CNT);
  assign empty    = (r_count == '0);
  assign overflow = r_overflow;

  // Storage array write; no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (push && !w_do_push) r_overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/scanner_serial_tx.sv
// Scanner-side serial transmitter: queues bytes, requests the link, then
// shifts whole bytes out one bit per clock, chaining bytes while granted.
module scanner_serial_tx #(
  parameter int DEPTH  = 8,
  parameter int BYTE_W = scanner_serial_tx_pkg::BYTE_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      loadByte,
  input  logic [BYTE_W-1:0]         loadData,
  input  logic                      startTransfer,
  input  logic                      readyForTransferIn,
  output logic                      readyForTransferOut,
  output logic                      dataOut,
  output logic                      sending,
  output logic [$clog2(BYTE_W)-1:0] bitCounter,
  output logic [$clog2(DEPTH):0]    fifoCount,
  output logic                      full,
  output logic                      empty,
  output logic                      overflow,
  output logic                      transferDone
);

  import scanner_serial_tx_pkg::state_t;
  import scanner_serial_tx_pkg::IDLE;
  import scanner_serial_tx_pkg::REQUEST;
  import scanner_serial_tx_pkg::SHIFT;
  import scanner_serial_tx_pkg::DONE;
  import scanner_serial_tx_pkg::MSB_FIRST;

  localparam int CW = $clog2(BYTE_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(BYTE_W - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [BYTE_W-1:0] r_shreg;
  logic [BYTE_W-1:0] w_shreg_next;
  logic [CW-1:0]     r_bit_cnt;
  logic [CW-1:0]     w_bit_cnt_next;
  logic              r_data_out;
  logic              w_data_out_next;
  logic              w_pop;
  logic              w_empty;
  logic [BYTE_W-1:0] w_fifo_rdata;
  logic [BYTE_W-1:0] w_load_word;
  logic [BYTE_W-1:0] w_load_shreg;

  byte_fifo #(
    .DEPTH (DEPTH),
    .W     (BYTE_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (loadByte),
    .pop      (w_pop),
    .wdata    (loadData),
    .rdata    (w_fifo_rdata),
    .count    (fifoCount),
    .full     (full),
    .empty    (w_empty),
    .overflow (overflow)
  );

  // The shifter always emits its top bit, so LSB-first order just reverses the word at load.
  for (genvar gi = 0; gi < BYTE_W; gi++) begin : g_order
    assign w_load_word[gi] = MSB_FIRST ? w_fifo_rdata[gi] : w_fifo_rdata[BYTE_W-1-gi];
  end

  // First bit goes straight to the line register; the rest wait in the shifter.
  assign w_load_shreg = {w_load_word[BYTE_W-2:0], 1'b0};

  assign empty               = w_empty;
  assign dataOut             = r_data_out;
  assign bitCounter          = r_bit_cnt;
  assign readyForTransferOut = (r_state == REQUEST);
  assign sending             = (r_state == SHIFT);
  assign transferDone        = (r_state == DONE);

  // Next-state, shifter and line logic; the line idles low outside SHIFT.
  always_comb begin
    w_state_next    = r_state;
    w_shreg_next    = r_shreg;
    w_bit_cnt_next  = r_bit_cnt;
    w_data_out_next = 1'b0;
    w_pop           = 1'b0;
    case (r_state)
      IDLE: begin
        if (startTransfer && !w_empty) w_state_next = REQUEST;
      end
      REQUEST: begin
        if (readyForTransferIn && !w_empty) begin
          w_pop           = 1'b1;
          w_state_next    = SHIFT;
          w_data_out_next = w_load_word[BYTE_W-1];
          w_shreg_next    = w_load_shreg;
          w_bit_cnt_next  = '0;
        end
      end
      SHIFT: begin
        if (r_bit_cnt != LAST_BIT) begin
          w_data_out_next = r_shreg[BYTE_W-1];
          w_shreg_next    = r_shreg << 1;
          w_bit_cnt_next  = r_bit_cnt + 1'b1;
        end else if (!w_empty && readyForTransferIn) begin
          w_pop           = 1'b1;
          w_data_out_next = w_load_word[BYTE_W-1];
          w_shreg_next    = w_load_shreg;
          w_bit_cnt_next  = '0;
        end else begin
          w_bit_cnt_next = '0;
          w_state_next   = w_empty ? DONE : REQUEST;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State, shifter and line registers; reset abandons any byte in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_data_out <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_shreg    <= w_shreg_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_data_out <= w_data_out_next;
    end
  end

endmodule

// File: tb/tb_scanner_serial_tx.sv
// Directed bench for scanner_serial_tx; inputs change and outputs are sampled on the falling edge.
module tb_scanner_serial_tx;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       loadByte = 1'b0;
  logic [7:0] loadData = 8'h00;
  logic       startTransfer = 1'b0;
  logic       readyForTransferIn = 1'b0;
  logic       readyForTransferOut;
  logic       dataOut;
  logic       sending;
  logic [2:0] bitCounter;
  logic [3:0] fifoCount;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       transferDone;

  int n_checks = 0;
  int n_pass   = 0;

  scanner_serial_tx #(.DEPTH(DEPTH), .BYTE_W(8)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .loadByte            (loadByte),
    .loadData            (loadData),
    .startTransfer       (startTransfer),
    .readyForTransferIn  (readyForTransferIn),
    .readyForTransferOut (readyForTransferOut),
    .dataOut             (dataOut),
    .sending             (sending),
    .bitCounter          (bitCounter),
    .fifoCount           (fifoCount),
    .full                (full),
    .empty               (empty),
    .overflow            (overflow),
    .transferDone        (transferDone)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Push one byte; returns on the falling edge after it was sampled.
  task automatic push(input logic [7:0] b);
    loadByte = 1'b1;
    loadData = b;
    @(negedge clk);
    loadByte = 1'b0;
    $display("push %02h count=%0d full=%0b overflow=%0b", b, fifoCount, full, overflow);
  endtask

  // Check 8 serial bits of byte b (MSB first); drop the grant after the bit at drop_at.
  task automatic expect_byte(input logic [7:0] b, input int drop_at);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("dataOut", dataOut, b[7-i]);
      check("bitCounter", bitCounter, i);
      check("sending", sending, 1);
      if (i == drop_at) readyForTransferIn = 1'b0;
    end
    $display("byte %02h shifted out", b);
  endtask

  initial begin
    logic [7:0] first_b;

    // Reset then idle.
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_dataOut", dataOut, 0);
      check("idle_rfto", readyForTransferOut, 0);
      check("idle_empty", empty, 1);
      check("idle_count", fifoCount, 0);
    end
    check("idle_sending", sending, 0);
    check("idle_done", transferDone, 0);
    check("idle_overflow", overflow, 0);
    $display("reset/idle done");

    // Start while empty is ignored.
    startTransfer = 1'b1;
    @(negedge clk);
    startTransfer = 1'b0;
    check("start_empty_rfto", readyForTransferOut, 0);
    @(negedge clk);
    check("start_empty_rfto2", readyForTransferOut, 0);
    $display("start while empty ignored");

    // Single byte with a delayed grant.
    push(8'hE0);
    check("single_count", fifoCount, 1);
    check("single_empty", empty, 0);
    startTransfer = 1'b1;
    @(negedge clk);
    startTransfer = 1'b0;
    check("single_rfto", readyForTransferOut, 1);
    repeat (2) begin
      @(negedge clk);
      check("single_wait_rfto", readyForTransferOut, 1);
      check("single_wait_send", sending, 0);
    end
    readyForTransferIn = 1'b1;
    expect_byte(8'hE0, 0);
    check("single_count0", fifoCount, 0);
    @(negedge clk);
    check("single_done", transferDone, 1);
    check("single_done_data", dataOut, 0);
    check("single_done_send", sending, 0);
    @(negedge clk);
    check("single_done_pulse", transferDone, 0);
    check("single_idle_rfto", readyForTransferOut, 0);
    $display("single byte transfer done");

    // Back-to-back bytes with continuous grant.
    push(8'hA5);
    push(8'h3C);
    startTransfer = 1'b1;
    @(negedge clk);
    startTransfer = 1'b0;
    check("b2b_rfto", readyForTransferOut, 1);
    readyForTransferIn = 1'b1;
    expect_byte(8'hA5, -1);
    expect_byte(8'h3C, -1);
    readyForTransferIn = 1'b0;
    @(negedge clk);
    check("b2b_done", transferDone, 1);
    @(negedge clk);
    check("b2b_done_pulse", transferDone, 0);
    $display("back-to-back transfer done");

    // Grant dropped mid-byte: byte completes, then wait in REQUEST.
    push(8'hC3);
    push(8'h5A);
    startTransfer = 1'b1;
    @(negedge clk);
    startTransfer = 1'b0;
    readyForTransferIn = 1'b1;
    expect_byte(8'hC3, 3);
    @(negedge clk);
    check("drop_rfto", readyForTransferOut, 1);
    check("drop_sending", sending, 0);
    check("drop_data", dataOut, 0);
    check("drop_count", fifoCount, 1);
    @(negedge clk);
    check("drop_rfto_wait", readyForTransferOut, 1);
    readyForTransferIn = 1'b1;
    expect_byte(8'h5A, 0);
    @(negedge clk);
    check("drop_done", transferDone, 1);
    @(negedge clk);
    $display("grant-drop transfer done");

    // Fill past capacity.
    for (int i = 0; i < DEPTH; i++) push(8'h81 + 8'(i));
    check("fill_full", full, 1);
    check("fill_count", fifoCount, DEPTH);
    check("fill_overflow0", overflow, 0);
    push(8'h77);
    check("ovf_flag", overflow, 1);
    check("ovf_count", fifoCount, DEPTH);
    check("ovf_full", full, 1);

    // Push coincident with the grant pop while full, then reset mid-byte.
    startTransfer = 1'b1;
    @(negedge clk);
    startTransfer = 1'b0;
    check("full_rfto", readyForTransferOut, 1);
    readyForTransferIn = 1'b1;
    loadByte = 1'b1;
    loadData = 8'hFF;
    first_b = 8'h81;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        loadByte = 1'b0;
        check("pushpop_count", fifoCount, DEPTH);
        check("pushpop_full", full, 1);
        check("pushpop_overflow", overflow, 1);
      end
      check("rstmid_data", dataOut, first_b[7-i]);
      check("rstmid_bit", bitCounter, i);
      if (i == 4) rst = 1'b0;
    end
    @(negedge clk);
    check("rstmid_dataOut", dataOut, 0);
    check("rstmid_sending", sending, 0);
    check("rstmid_count", fifoCount, 0);
    check("rstmid_empty", empty, 1);
    check("rstmid_overflow", overflow, 0);
    check("rstmid_bitcnt", bitCounter, 0);
    check("rstmid_rfto", readyForTransferOut, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_idle_rfto", readyForTransferOut, 0);
    check("rstmid_idle_send", sending, 0);
    readyForTransferIn = 1'b0;
    $display("reset mid-byte done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/scanner_serial_tx.md
Name: scanner_serial_tx

Overview:
- Scanner-side serial transmitter. It is the sending end of the one-bit link into the transfer center's serial receiver.
- The scanner pushes bytes into a small FIFO. The block requests a transfer, waits for the transfer center to grant it, then shifts each byte out MSB-first, one bit per clock.
- The receiver side assembles 8 consecutive bits into one byte, so bytes are always sent whole and never split.

Parameters:
- DEPTH, 8, FIFO capacity in bytes; must be a power of two, at least 2.
- BYTE_W, 8, bits per serial word; fixed by the link and not overridden in practice.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- loadByte  input  1  push loadData into the FIFO this cycle.
- loadData  input  8  byte to enqueue.
- startTransfer  input  1  scanner command to begin sending the queued bytes.
- readyForTransferIn  input  1  grant/ready from the transfer center.
- readyForTransferOut  output  1  request to the transfer center; high only in state REQUEST.
- dataOut  output  1  serial data line, registered.
- sending  output  1  high while a byte is on the line (state SHIFT).
- bitCounter  output  3  index of the bit currently on dataOut; 0 = MSB.
- fifoCount  output  log2(DEPTH)+1  number of bytes queued.
- full  output  1  fifoCount == DEPTH.
- empty  output  1  fifoCount == 0.
- overflow  output  1  sticky: a push was attempted while full.
- transferDone  output  1  one-cycle pulse when the queue has drained.

Behaviour:
- Reset (rst==0 at a clock edge):
  - FIFO pointers and count go to 0; empty=1, full=0, overflow=0.
  - State goes to IDLE; dataOut, sending, bitCounter, readyForTransferOut and transferDone all go to 0.
  - Reset wins over every other input, including mid-byte. A byte in flight is abandoned and the line returns to 0 on the next cycle.
- FIFO:
  - Circular buffer; read and write pointers wrap modulo DEPTH.
  - A push while full is dropped, sets overflow, and leaves count unchanged.
  - A pop happens only when a byte is loaded into the shift register.
  - A push and a pop in the same cycle are both performed and count is unchanged. This holds when full, because the pop frees a slot that cycle.
  - A push into an empty FIFO is not poppable until the next cycle (no bypass path).
- State IDLE:
  - dataOut=0.
  - startTransfer && !empty → REQUEST.
  - startTransfer while empty is ignored.
- State REQUEST:
  - readyForTransferOut=1.
  - On readyForTransferIn==1, the head byte loads into the shift register, the FIFO pops, and state → SHIFT.
  - The MSB appears on dataOut in the cycle after the grant is sampled (1-cycle latency).
  - The block waits in REQUEST indefinitely; there is no timeout.
- State SHIFT:
  - dataOut = shreg[7]; the register shifts left each cycle; bitCounter runs 0→7.
  - A byte occupies exactly 8 consecutive cycles.
  - readyForTransferIn is ignored mid-byte; the byte always completes.
- Decision at bitCounter==7:
  - !empty && readyForTransferIn: load the next byte and pop. The next MSB goes out in the following cycle with no gap, and bitCounter wraps to 0.
  - !empty && !readyForTransferIn: → REQUEST.
  - empty: → DONE.
- State DONE:
  - transferDone=1 for exactly one cycle, dataOut=0, then → IDLE.
- Loading new bytes during SHIFT is legal. A byte pushed before the bitCounter==7 cycle is sent in the same burst.
- State encoding: IDLE=0, REQUEST=1, SHIFT=2, DONE=3.

Decomposition:
- Shared package holds:
  - BYTE_W and the state encodings IDLE/REQUEST/SHIFT/DONE.
  - The bit-order constant MSB_FIRST=1, which the receiver also uses.
- One sub-module, byte_fifo:
  - Parameterised by DEPTH.
  - Ports: push, pop, wdata, rdata, count, full, empty, overflow.
  - rdata is combinational from the read pointer (show-ahead).
- The FSM and shift register live in scanner_serial_tx.

Test Plan:
- Reset then idle: hold rst=0 for 2 cycles, release, run 5 cycles → dataOut=0, readyForTransferOut=0, empty=1, fifoCount=0 throughout.
- Single byte: push 8'hE0, pulse startTransfer; readyForTransferOut=1; assert readyForTransferIn 3 cycles later.
  - dataOut sequence is 1,1,1,0,0,0,0,0 starting the cycle after the grant, with bitCounter 0..7.
  - transferDone pulses once; state returns to IDLE.
- Back-to-back: push 8'hA5 and 8'h3C, keep readyForTransferIn=1 → 16 contiguous bits 10100101 00111100 with no gap, then transferDone.
- Grant drop: queue 2 bytes; deassert readyForTransferIn at bit 3 of byte 1.
  - Byte 1 completes all 8 bits, then the block sits in REQUEST.
  - Re-grant → byte 2 sent.
- FIFO full/overflow: push DEPTH+1 bytes with no start → full=1, fifoCount=DEPTH, overflow=1.
  - Then a simultaneous push and pop during the transfer leaves fifoCount unchanged.
- Reset mid-byte: assert rst=0 at bitCounter=4 → next cycle dataOut=0, sending=0, fifoCount=0, state IDLE.
